mem_resp_router: RTL

- Sits directly downstream of the instruction/data memory-request arbiter, on the return path from memory.
- Snoops each issued request (id, source, write bit) into an outstanding-request table indexed by id.
- Routes each memory response back to the instruction port or data port using that table.
- Provides occupancy and full status so upstream can throttle, and flags protocol errors.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/pend_table.sv | 69 ++++++
 rtl/mem_resp_router.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory response router: request source encoding,
// outstanding-table entry layout and the table depth helper.
package mem_pkg;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } mem_src_e;

  typedef struct packed {
    logic     valid;
    mem_src_e src;
    logic     write;
  } pend_entry_t;

  function automatic int unsigned depth_of(input int unsigned id_width);
    return 32'd1 << id_width;
  endfunction

endpackage

// File: rtl/pend_table.sv
// Outstanding-request table indexed by request id, with one install port,
// one retire port, a combinational lookup port and the occupancy counter.
module pend_table
  import mem_pkg::*;
#(
  parameter int ID_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                install_en_i,
  input  logic [ID_WIDTH-1:0] install_id_i,
  input  mem_src_e            install_src_i,
  input  logic                install_write_i,
  input  logic                retire_en_i,
  input  logic [ID_WIDTH-1:0] retire_id_i,
  input  logic [ID_WIDTH-1:0] lookup_id_i,
  output pend_entry_t         lookup_o,
  output logic                collision_o,
  output logic [ID_WIDTH:0]   count_o,
  output logic                full_o
);

  localparam int DEPTH = int'(depth_of(ID_WIDTH));
  localparam logic [ID_WIDTH:0] FULL_CNT = (ID_WIDTH+1)'(DEPTH);

  pend_entry_t       entries_q [DEPTH];
  pend_entry_t       entries_d [DEPTH];
  logic [ID_WIDTH:0] count_q, count_d;
  logic              full_q, full_d;
  logic              retire, slot_busy, install_new;

  // Retire is applied before install so a same-id response/request pair
  // leaves the slot holding the new request without counting as a collision.
  always_comb begin
    retire      = retire_en_i && entries_q[retire_id_i].valid;
    slot_busy   = entries_q[install_id_i].valid &&
                  !(retire && (retire_id_i == install_id_i));
    install_new = install_en_i && !slot_busy;
    collision_o = install_en_i && slot_busy;
    lookup_o    = entries_q[lookup_id_i];

    entries_d = entries_q;
    if (retire) begin
      entries_d[retire_id_i].valid = 1'b0;
    end
    if (install_en_i) begin
      entries_d[install_id_i] = '{valid: 1'b1, src: install_src_i, write: install_write_i};
    end

    count_d = count_q + (ID_WIDTH+1)'(install_new) - (ID_WIDTH+1)'(retire);
    full_d  = (count_d == FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '{default: '0};
      count_q   <= '0;
      full_q    <= 1'b0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
      full_q    <= full_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = full_q;

endmodule

// File: rtl/mem_resp_router.sv
// Routes memory responses to the instruction or data port using the
// outstanding-request table, with registered outputs and a sticky error flag.
module mem_resp_router
  import mem_pkg::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int ID_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_enable,
  input  logic [ID_WIDTH-1:0]     i_req_id,
  input  logic                    i_req_src,
  input  logic                    i_req_write,
  input  logic                    i_resp_valid,
  input  logic [ID_WIDTH-1:0]     i_resp_id,
  input  logic [LINE_BYTES*8-1:0] i_resp_data,
  output logic                    o_instr_valid,
  output logic [LINE_BYTES*8-1:0] o_instr_data,
  output logic                    o_data_valid,
  output logic [LINE_BYTES*8-1:0] o_data_data,
  output logic                    o_data_wack,
  output logic [ID_WIDTH:0]       o_outstanding,
  output logic                    o_full,
  output logic                    o_err
);

  localparam int DW = LINE_BYTES * 8;

  pend_entry_t   lookup;
  logic          collision;
  logic          instr_valid_q, instr_valid_d;
  logic          data_valid_q, data_valid_d;
  logic          wack_q, wack_d;
  logic [DW-1:0] instr_data_q, instr_data_d;
  logic [DW-1:0] data_data_q, data_data_d;
  logic          err_q, err_d;

  pend_table #(
    .ID_WIDTH(ID_WIDTH)
  ) u_pend_table (
    .clk            (clk),
    .rst            (rst),
    .install_en_i   (i_req_enable),
    .install_id_i   (i_req_id),
    .install_src_i  (mem_src_e'(i_req_src)),
    .install_write_i(i_req_write),
    .retire_en_i    (i_resp_valid),
    .retire_id_i    (i_resp_id),
    .lookup_id_i    (i_resp_id),
    .lookup_o       (lookup),
    .collision_o    (collision),
    .count_o        (o_outstanding),
    .full_o         (o_full)
  );

  // A write flag on an instruction entry is routed as a read but flagged.
  always_comb begin
    instr_valid_d = 1'b0;
    data_valid_d  = 1'b0;
    wack_d        = 1'b0;
    instr_data_d  = instr_data_q;
    data_data_d   = data_data_q;
    err_d         = err_q | collision;

    if (i_resp_valid) begin
      if (!lookup.valid) begin
        err_d = 1'b1;
      end else if (lookup.src == SRC_INSTR) begin
        instr_valid_d = 1'b1;
        instr_data_d  = i_resp_data;
        if (lookup.write) begin
          err_d = 1'b1;
        end
      end else if (lookup.write) begin
        wack_d = 1'b1;
      end else begin
        data_valid_d = 1'b1;
        data_data_d  = i_resp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      wack_q        <= 1'b0;
      instr_data_q  <= '0;
      data_data_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      instr_valid_q <= instr_valid_d;
      data_valid_q  <= data_valid_d;
      wack_q        <= wack_d;
      instr_data_q  <= instr_data_d;
      data_data_q   <= data_data_d;
      err_q         <= err_d;
    end
  end

  assign o_instr_valid = instr_valid_q;
  assign o_instr_data  = instr_data_q;
  assign o_data_valid  = data_valid_q;
  assign o_data_data   = data_data_q;
  assign o_data_wack   = wack_q;
  assign o_err         = err_q;

endmodule
